roi_max_scan: RTL and testbench

Streaming front end for the Sobel mask path. It accepts the Sobel magnitude stream of one ROI frame, `NUM_PER_CYCLE` pixels per beat. It forwards the stream unchanged, one cycle later, into the mask/normalise stage. It also tracks the maximum magnitude over the ROI interior, which excludes a `MASK_SIZE` border on every side. At frame end it latches that maximum as the divisor the normalise stage uses.

---
 rtl/roi_pkg.sv | 20 ++
 rtl/lane_max_tree.sv | 58 +++++
 rtl/roi_max_scan.sv | 106 ++++++++++
 tb/tb_roi_max_scan.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/roi_pkg.sv
// Shared constants, types and helpers for the ROI max-scan front end.
package roi_pkg;

  localparam int ROI_SIZE        = 480;
  localparam int MASK_SIZE       = 6;
  localparam int NUM_PER_CYCLE   = 2;
  localparam int IN_WIDTH        = 12;
  localparam int OUT_WIDTH       = 12;
  localparam int HW_BITS         = $clog2(ROI_SIZE);
  localparam int BEATS_PER_FRAME = ROI_SIZE * ROI_SIZE / NUM_PER_CYCLE;

  typedef logic        [IN_WIDTH-1:0]  pixel_t;
  typedef logic signed [OUT_WIDTH-1:0] norm_t;

  // Largest positive value of a signed word of the given width.
  function automatic int sat_limit(input int out_width);
    return (1 << (out_width - 1)) - 1;
  endfunction

endpackage

// File: rtl/lane_max_tree.sv
// Saturates the interior lanes of one beat and reduces them to the beat max.
// The reduction is a single level of all-pairs compares followed by a one-hot
// select, so it stays shallow as the lane count grows.
module lane_max_tree
  import roi_pkg::*;
#(
  parameter int NUM_LANES = roi_pkg::NUM_PER_CYCLE,
  parameter int IN_WIDTH  = roi_pkg::IN_WIDTH,
  parameter int OUT_WIDTH = roi_pkg::OUT_WIDTH
) (
  input  logic [IN_WIDTH-1:0]  lane_val [NUM_LANES],
  input  logic                 lane_in  [NUM_LANES],
  output logic [OUT_WIDTH-2:0] beat_max
);

  localparam int MAG_W = OUT_WIDTH - 1;
  localparam int EXT_W = (IN_WIDTH > MAG_W) ? IN_WIDTH : MAG_W;
  localparam int SAT   = sat_limit(OUT_WIDTH);

  logic [MAG_W-1:0] sat_val [NUM_LANES];
  logic             win     [NUM_LANES];

  // Zero-extend, saturate, and zero out lanes that lie in the border.
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      // NOTE: every combinational output gets a value on every path; a missing
      // default here would infer a latch.
      sat_val[k] = '0;
      if (lane_in[k]) begin
        if (EXT_W'(lane_val[k]) > EXT_W'(SAT))
          sat_val[k] = MAG_W'(SAT);
        else
          sat_val[k] = MAG_W'(EXT_W'(lane_val[k]));
      end
    end
  end

  // Exactly one lane wins: strictly above earlier lanes, at least equal to later ones.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      win[i] = 1'b1;
      for (int j = 0; j < NUM_LANES; j++) begin
        if (j < i)
          win[i] = win[i] & (sat_val[i] > sat_val[j]);
        else if (j > i)
          win[i] = win[i] & (sat_val[i] >= sat_val[j]);
      end
    end
  end

  // One-hot select of the winning lane.
  always_comb begin
    beat_max = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (win[i]) beat_max = beat_max | sat_val[i];
  end

endmodule

// File: rtl/roi_max_scan.sv
// Forwards the Sobel magnitude stream one cycle late and latches the maximum
// over the ROI interior at the end of each complete frame.
module roi_max_scan
  import roi_pkg::*;
#(
  parameter int ROI_SIZE      = roi_pkg::ROI_SIZE,
  parameter int IN_WIDTH      = roi_pkg::IN_WIDTH,
  parameter int OUT_WIDTH     = roi_pkg::OUT_WIDTH,
  parameter int MASK_SIZE     = roi_pkg::MASK_SIZE,
  parameter int NUM_PER_CYCLE = roi_pkg::NUM_PER_CYCLE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic [IN_WIDTH-1:0]         din [NUM_PER_CYCLE],
  input  logic                        din_valid,
  output logic [IN_WIDTH-1:0]         dout [NUM_PER_CYCLE],
  output logic                        dout_valid,
  output logic signed [OUT_WIDTH-1:0] max,
  output logic                        max_valid,
  output logic                        frame_done
);

  localparam int HW    = $clog2(ROI_SIZE);
  localparam int CW    = HW + 1;
  localparam int MAG_W = OUT_WIDTH - 1;
  localparam int LO    = MASK_SIZE;
  localparam int HI    = ROI_SIZE - MASK_SIZE - 1;

  logic [HW-1:0]    row, col;
  logic [MAG_W-1:0] run_max;
  logic [MAG_W-1:0] beat_max;
  logic [MAG_W-1:0] frame_max;
  logic             lane_in [NUM_PER_CYCLE];
  logic             row_in;
  logic             last_beat;
  logic             col_wrap;

  // Interior flags per lane, end-of-row/frame detection and the frame max.
  always_comb begin
    row_in    = (row >= HW'(LO)) && (row <= HW'(HI));
    for (int k = 0; k < NUM_PER_CYCLE; k++)
      lane_in[k] = row_in &&
                   ((CW'(col) + CW'(k)) >= CW'(LO)) &&
                   ((CW'(col) + CW'(k)) <= CW'(HI));
    col_wrap  = (col == HW'(ROI_SIZE - NUM_PER_CYCLE));
    last_beat = col_wrap && (row == HW'(ROI_SIZE - 1));
    frame_max = (run_max > beat_max) ? run_max : beat_max;
  end

  lane_max_tree #(
    .NUM_LANES (NUM_PER_CYCLE),
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_lane_max_tree (
    .lane_val (din),
    .lane_in  (lane_in),
    .beat_max (beat_max)
  );

  // Position counters, running max, stream delay and latched result.
  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '0;
      col        <= '0;
      run_max    <= '0;
      // NOTE: the output lanes are a handful of flops, not a RAM, so they are
      // cleared in reset like any other register.
      for (int k = 0; k < NUM_PER_CYCLE; k++) dout[k] <= '0;
      dout_valid <= 1'b0;
      max        <= '0;
      max_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (clk_en) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      for (int k = 0; k < NUM_PER_CYCLE; k++) dout[k] <= din[k];
      dout_valid <= din_valid;
      frame_done <= 1'b0;
      if (din_valid) begin
        if (last_beat) begin
          max        <= (frame_max == '0) ? OUT_WIDTH'(1) : $signed({1'b0, frame_max});
          max_valid  <= 1'b1;
          frame_done <= 1'b1;
          row        <= '0;
          col        <= '0;
          run_max    <= '0;
        end else begin
          run_max <= frame_max;
          if (col_wrap) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + HW'(NUM_PER_CYCLE);
          end
        end
      end else begin
        // A gap inside a frame abandons it; outside a frame this is a no-op.
        row     <= '0;
        col     <= '0;
        run_max <= '0;
      end
    end
  end

endmodule

// File: tb/tb_roi_max_scan.sv
// Self-checking bench for roi_max_scan on a 16x16 ROI with a 2-pixel border.
module tb_roi_max_scan;

  localparam int ROI   = 16;
  localparam int MASK  = 2;
  localparam int N     = 2;
  localparam int IW    = 12;
  localparam int OW    = 12;
  localparam int BEATS = ROI * ROI / N;
  localparam int SATV  = (1 << (OW - 1)) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clk_en;
  logic [IW-1:0]        din  [N];
  logic                 din_valid;
  logic [IW-1:0]        dout [N];
  logic                 dout_valid;
  logic signed [OW-1:0] max_o;
  logic                 max_valid;
  logic                 frame_done;

  int checks   = 0;
  int failures = 0;
  int pix [ROI][ROI];
  int exp_latched;
  int exp_mv;

  roi_max_scan #(
    .ROI_SIZE      (ROI),
    .IN_WIDTH      (IW),
    .OUT_WIDTH     (OW),
    .MASK_SIZE     (MASK),
    .NUM_PER_CYCLE (N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .max        (max_o),
    .max_valid  (max_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: max over the interior of the saturated pixels, floored to 1.
  function automatic int model_max();
    int m = 0;
    for (int r = MASK; r <= ROI - MASK - 1; r++)
      for (int c = MASK; c <= ROI - MASK - 1; c++) begin
        int v = (pix[r][c] > SATV) ? SATV : pix[r][c];
        if (v > m) m = v;
      end
    return (m == 0) ? 1 : m;
  endfunction

  task automatic fill_ramp();
    for (int r = 0; r < ROI; r++)
      for (int c = 0; c < ROI; c++) pix[r][c] = r * ROI + c;
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < ROI; r++)
      for (int c = 0; c < ROI; c++) pix[r][c] = v;
  endtask

  task automatic fill_random(input int hi);
    for (int r = 0; r < ROI; r++)
      for (int c = 0; c < ROI; c++) pix[r][c] = int'($urandom_range(0, hi));
  endtask

  // One accepted beat b of the current picture, then check the outputs.
  task automatic beat(input int b);
    int r = b / (ROI / N);
    int c = (b % (ROI / N)) * N;
    for (int k = 0; k < N; k++) din[k] = IW'(pix[r][c + k]);
    din_valid = 1'b1;
    clk_en    = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) check("dout_lane", dout[k], din[k]);
    check("dout_valid", dout_valid, 1);
    if (b == BEATS - 1) begin
      exp_latched = model_max();
      exp_mv      = 1;
      check("frame_done_last", frame_done, 1);
    end else begin
      check("frame_done_mid", frame_done, 0);
    end
    check("max", max_o, exp_latched);
    check("max_valid", max_valid, exp_mv);
  endtask

  // Enabled cycle with din_valid low and random data on the lanes.
  task automatic idle();
    for (int k = 0; k < N; k++) din[k] = IW'($urandom);
    din_valid = 1'b0;
    clk_en    = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) check("idle_dout", dout[k], din[k]);
    check("idle_dout_valid", dout_valid, 0);
    check("idle_frame_done", frame_done, 0);
    check("idle_max", max_o, exp_latched);
    check("idle_max_valid", max_valid, exp_mv);
  endtask

  // clk_en low for len cycles with garbage inputs: everything must hold.
  task automatic stall(input int len);
    logic [IW-1:0] sd [N];
    logic          sv;
    for (int k = 0; k < N; k++) sd[k] = dout[k];
    sv = dout_valid;
    for (int i = 0; i < len; i++) begin
      for (int k = 0; k < N; k++) din[k] = IW'($urandom);
      din_valid = 1'($urandom);
      clk_en    = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) check("stall_dout", dout[k], sd[k]);
      check("stall_dout_valid", dout_valid, sv);
      check("stall_frame_done", frame_done, 0);
      check("stall_max", max_o, exp_latched);
    end
  endtask

  task automatic run_frame(input int stall_at, input int stall_len, input bit trail_idle);
    for (int b = 0; b < BEATS; b++) begin
      if (b == stall_at) stall(stall_len);
      beat(b);
    end
    if (trail_idle) idle();
  endtask

  task automatic apply_reset();
    for (int k = 0; k < N; k++) din[k] = IW'($urandom);
    din_valid = 1'b1;
    clk_en    = 1'b1;
    rst       = 1'b1;
    @(posedge clk); #1;
    exp_latched = 0;
    exp_mv      = 0;
    for (int k = 0; k < N; k++) check("rst_dout", dout[k], 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_max", max_o, 0);
    check("rst_max_valid", max_valid, 0);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    clk_en    = 1'b0;
    din_valid = 1'b0;
    for (int k = 0; k < N; k++) din[k] = '0;
    exp_latched = 0;
    exp_mv      = 0;
    @(posedge clk); #1;
    apply_reset();

    // Ramp frame: interior peak at (13,13) = 221.
    fill_ramp();
    run_frame(-1, 0, 1'b1);
    check("ramp_model", exp_latched, 221);

    // Ramp again, followed back-to-back by a frame whose hot pixels sit in the border.
    run_frame(-1, 0, 1'b0);
    fill_const(7);
    pix[0][0]   = 4095;
    pix[15][15] = 4095;
    pix[1][8]   = 4095;
    run_frame(-1, 0, 1'b1);
    check("border_model", exp_latched, 7);

    // Single interior hot pixel saturates.
    fill_const(0);
    pix[5][5] = 4095;
    run_frame(-1, 0, 1'b1);
    check("sat_model", exp_latched, 2047);

    // All-zero frame floors to 1.
    fill_const(0);
    run_frame(-1, 0, 1'b1);
    check("zero_model", exp_latched, 1);

    // Abort after beat 50 with a one-cycle gap, then a full ramp frame.
    fill_random(4095);
    for (int b = 0; b <= 50; b++) beat(b);
    idle();
    fill_ramp();
    run_frame(-1, 0, 1'b1);

    // Random frame with a 5-cycle stall in the middle.
    fill_random(3000);
    run_frame(37, 5, 1'b1);

    // A few random frames, some small-valued to exercise the non-saturating path.
    fill_random(4095);
    run_frame(-1, 0, 1'b1);
    fill_random(300);
    run_frame(90, 3, 1'b0);
    fill_random(1500);
    run_frame(-1, 0, 1'b1);

    // Reset in the middle of a frame, then a clean random frame.
    fill_random(4095);
    for (int b = 0; b < 40; b++) beat(b);
    apply_reset();
    fill_random(2047);
    run_frame(-1, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
